// File: rtl/ts_scurve_pkg.sv
// Shared definitions for the threshold-sweep sequencer: default widths,
// FSM state encoding and FoundMask bit positions.
package ts_scurve_pkg;

    localparam int DEF_DAC_W      = 10;
    localparam int DEF_ACC_W      = 12;
    localparam int DEF_NINJ       = 1000;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_TIMEOUT    = 4095;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SET_DAC = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
    localparam logic [2:0] ST_WAIT_LO = 3'd5;
    localparam logic [2:0] ST_EVAL    = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam int FM_FULL = 0;
    localparam int FM_HALF = 1;
    localparam int FM_ZERO = 2;

endpackage

// File: rtl/ts_scurve_eval.sv
// S-curve crossing detector: on each evaluated point, classifies the
// accumulated count against full/half/zero efficiency and records the
// threshold code at which each crossing occurs.
module ts_scurve_eval
    import ts_scurve_pkg::*;
#(
    parameter int DAC_W = DEF_DAC_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int NINJ  = DEF_NINJ
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [DAC_W-1:0] i_th,
    output logic [DAC_W-1:0] o_th_full,
    output logic [DAC_W-1:0] o_th_half,
    output logic [DAC_W-1:0] o_th_zero,
    output logic [2:0]       o_found
);

    logic             w_is_full;
    logic             w_is_half;
    logic             w_is_zero;
    logic [DAC_W-1:0] r_th_full;
    logic [DAC_W-1:0] r_th_half;
    logic [DAC_W-1:0] r_th_zero;
    logic [2:0]       r_found;

    // Pile-up (Acc above NINJ) still counts as full efficiency.
    assign w_is_full = (i_acc >= ACC_W'(NINJ));
    assign w_is_half = (i_acc <= ACC_W'(NINJ / 2));
    assign w_is_zero = (i_acc == '0);

    // Full tracks the last hit; half and zero latch the first hit only,
    // so a noisy non-monotonic tail cannot move them.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clr) begin
            r_th_full <= '0;
            r_th_half <= '0;
            r_th_zero <= '0;
            r_found   <= '0;
        end else if (i_en) begin
            if (w_is_full) begin
                r_th_full        <= i_th;
                r_found[FM_FULL] <= 1'b1;
            end
            if (!r_found[FM_HALF] && w_is_half) begin
                r_th_half        <= i_th;
                r_found[FM_HALF] <= 1'b1;
            end
            if (!r_found[FM_ZERO] && w_is_zero) begin
                r_th_zero        <= i_th;
                r_found[FM_ZERO] <= 1'b1;
            end
        end
    end

    assign o_th_full = r_th_full;
    assign o_th_half = r_th_half;
    assign o_th_zero = r_th_zero;
    assign o_found   = r_found;

endmodule

// File: rtl/ts_scurve_sweep.sv
// Threshold-sweep sequencer: steps the discriminator DAC from ThStart to
// ThStop, launches one ts_scurve scan per code, and hands each finished
// Acc to the crossing detector.
module ts_scurve_sweep
    import ts_scurve_pkg::*;
#(
    parameter int DAC_W      = DEF_DAC_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int NINJ       = DEF_NINJ,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             SweepStart,
    input  logic             Abort,
    input  logic [DAC_W-1:0] ThStart,
    input  logic [DAC_W-1:0] ThStop,
    input  logic [3:0]       ThStep,
    input  logic             ScanBusy,
    input  logic [ACC_W-1:0] Acc,
    output logic [DAC_W-1:0] TH,
    output logic             ScanStart,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [DAC_W-1:0] ThFull,
    output logic [DAC_W-1:0] ThHalf,
    output logic [DAC_W-1:0] ThZero,
    output logic [2:0]       FoundMask
);

    // One counter serves both the settle wait and the ScanBusy timeouts.
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       r_state;
    logic             r_sweep_prev;
    logic [DAC_W-1:0] r_th;
    logic [DAC_W-1:0] r_stop;
    logic [3:0]       r_step;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_start_edge;
    logic             w_eval_clr;
    logic             w_eval_en;
    logic [3:0]       w_step;
    logic [DAC_W:0]   w_next;
    logic             w_last;
    logic             w_timeout;

    assign w_start_edge = SweepStart & ~r_sweep_prev;
    assign w_eval_clr   = (r_state == ST_IDLE) & w_start_edge;
    assign w_eval_en    = (r_state == ST_EVAL);
    assign w_step       = (r_step == 4'd0) ? 4'd1 : r_step;
    // Extra MSB catches overflow past the top DAC code so it never wraps to 0.
    assign w_next       = {1'b0, r_th} + {{(DAC_W - 3){1'b0}}, w_step};
    assign w_last       = (w_next > {1'b0, r_stop});
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));

    // Sweep sequencing FSM with its shared cycle counter and sticky status.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state      <= ST_IDLE;
            r_sweep_prev <= 1'b0;
            r_th         <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_sweep_prev <= SweepStart;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_th    <= ThStart;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_SET_DAC;
                    end
                end
                ST_SET_DAC: begin
                    r_cnt   <= '0;
                    r_state <= (r_th > r_stop) ? ST_DONE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (Abort) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (ScanBusy) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_LO;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!ScanBusy) begin
                        r_state <= ST_EVAL;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    r_cnt <= '0;
                    if (Abort || w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_th    <= w_next[DAC_W-1:0];
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sweep limits are frozen at start; Acc is captured the cycle ScanBusy is first seen low.
    always_ff @(posedge CLK) begin
        if ((r_state == ST_IDLE) && w_start_edge) begin
            r_stop <= ThStop;
            r_step <= ThStep;
        end
        if ((r_state == ST_WAIT_LO) && !ScanBusy) begin
            r_acc <= Acc;
        end
    end

    ts_scurve_eval #(
        .DAC_W (DAC_W),
        .ACC_W (ACC_W),
        .NINJ  (NINJ)
    ) u_eval (
        .i_clk     (CLK),
        .i_rstn    (RSTn),
        .i_clr     (w_eval_clr),
        .i_en      (w_eval_en),
        .i_acc     (r_acc),
        .i_th      (r_th),
        .o_th_full (ThFull),
        .o_th_half (ThHalf),
        .o_th_zero (ThZero),
        .o_found   (FoundMask)
    );

    assign TH        = r_th;
    assign ScanStart = (r_state == ST_START);
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Err       = r_err;

endmodule
